// File: rtl/sysid_pkg.sv
// -----------------------------------------------------------------------------
// sysid_pkg
// Shared definitions for the sysid check master: the check-sequence state
// encoding, the Avalon-MM word addresses of the sysid slave registers and the
// width of the waitrequest stall counter.
// -----------------------------------------------------------------------------
package sysid_pkg;

   // Check sequence: wait for start, read ID word, read timestamp word, report.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_ID  = 2'd1,
      RD_TS  = 2'd2,
      FINISH = 2'd3
   } sysid_state_t;

   // Word addresses inside the sysid slave.
   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;

   // Width of the per-read stall counter (limits up to 65535 cycles).
   localparam int STALL_W = 16;

endpackage

// File: rtl/sysid_stall_timer.sv
// -----------------------------------------------------------------------------
// sysid_stall_timer
// Counts cycles during which the current read is stalled by waitrequest and
// flags the cycle on which the stall budget is used up.
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset, counter -> 0
//   clear    in   restart the count at 0 (no read in flight, or read completed)
//   enable   in   one more stalled cycle is being spent this cycle
//   limit    in   stall budget in cycles (1..65535)
//   expired  out  this stalled cycle is number 'limit' of the current read
// -----------------------------------------------------------------------------
module sysid_stall_timer
   import sysid_pkg::*;
(
   input  logic               clock,
   input  logic               reset_n,
   input  logic               clear,
   input  logic               enable,
   input  logic [STALL_W-1:0] limit,
   output logic               expired
);

   logic [STALL_W-1:0] count_q;

   // Stalled-cycle counter: cleared whenever no read is waiting, otherwise
   // advanced once per stalled cycle. It never passes limit-1 because the
   // master leaves the read state on the expiring cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + STALL_W'(1);
      end
   end

   // Expiry is seen on the stalled cycle that would bring the count to limit,
   // so the master aborts after exactly 'limit' stalled cycles.
   assign expired = enable && (count_q == (limit - STALL_W'(1)));

endmodule

// File: rtl/sysid_check_master.sv
// -----------------------------------------------------------------------------
// sysid_check_master
// Avalon-MM master that reads the system ID word (address 0) and the build
// timestamp word (address 1) from a sysid slave, compares them against the
// expected values and reports the result. A read stalled by waitrequest for
// TIMEOUT_CYCLES cycles aborts the sequence with timeout set.
//
// Parameters:
//   EXP_ID          expected system ID word
//   EXP_TIMESTAMP   expected build timestamp word
//   TIMEOUT_CYCLES  stalled cycles allowed per read (1..65535)
//
// Ports:
//   clock, reset_n       clock and asynchronous active-low reset
//   start                single-cycle request, accepted only when idle
//   avm_address/avm_read registered Avalon-MM read command
//   avm_readdata         slave read data
//   avm_waitrequest      slave stall
//   busy                 sequence in progress
//   done                 one-cycle pulse at the end of a sequence
//   id_ok / ts_ok        captured words matched the expected values
//   timeout              last sequence was aborted on the stall limit
//   id_value / ts_value  last captured ID / timestamp words
// -----------------------------------------------------------------------------
module sysid_check_master
   import sysid_pkg::*;
#(
   parameter logic [31:0] EXP_ID         = 32'h0000_0000,
   parameter logic [31:0] EXP_TIMESTAMP  = 32'd1536932732,
   parameter int          TIMEOUT_CYCLES = 256
)(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES);

   sysid_state_t state_q;
   logic         in_read;
   logic         stall_clear;
   logic         stall_enable;
   logic         stall_expired;

   // A read is outstanding in both read states; the stall counter restarts
   // whenever no read is waiting or the current read completes, which gives
   // each read state a fresh budget on entry.
   assign in_read      = (state_q == RD_ID) || (state_q == RD_TS);
   assign stall_enable = in_read && avm_waitrequest;
   assign stall_clear  = !in_read || !avm_waitrequest;

   sysid_stall_timer u_stall_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (stall_clear),
      .enable  (stall_enable),
      .limit   (STALL_LIMIT),
      .expired (stall_expired)
   );

   // Check sequence state machine. The read command only changes when a
   // transfer completes or the stall budget expires, so address and read stay
   // stable across waitrequest. done is raised on the edge entering FINISH so
   // it lines up with the final id_ok/ts_ok/timeout values; starts seen in any
   // state other than IDLE (including FINISH) are dropped.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         avm_address <= ADDR_ID;
         avm_read    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         id_ok       <= 1'b0;
         ts_ok       <= 1'b0;
         timeout     <= 1'b0;
         id_value    <= '0;
         ts_value    <= '0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q     <= RD_ID;
                  busy        <= 1'b1;
                  avm_read    <= 1'b1;
                  avm_address <= ADDR_ID;
                  id_ok       <= 1'b0;
                  ts_ok       <= 1'b0;
                  timeout     <= 1'b0;
               end
            end
            RD_ID: begin
               if (!avm_waitrequest) begin
                  id_value    <= avm_readdata;
                  avm_address <= ADDR_TS;
                  state_q     <= RD_TS;
               end else if (stall_expired) begin
                  avm_read    <= 1'b0;
                  avm_address <= ADDR_ID;
                  timeout     <= 1'b1;
                  done        <= 1'b1;
                  state_q     <= FINISH;
               end
            end
            RD_TS: begin
               if (!avm_waitrequest) begin
                  ts_value    <= avm_readdata;
                  id_ok       <= (id_value == EXP_ID);
                  ts_ok       <= (avm_readdata == EXP_TIMESTAMP);
                  avm_read    <= 1'b0;
                  avm_address <= ADDR_ID;
                  done        <= 1'b1;
                  state_q     <= FINISH;
               end else if (stall_expired) begin
                  avm_read    <= 1'b0;
                  avm_address <= ADDR_ID;
                  timeout     <= 1'b1;
                  done        <= 1'b1;
                  state_q     <= FINISH;
               end
            end
            FINISH: begin
               busy    <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sysid_check_master.sv
// -----------------------------------------------------------------------------
// tb_sysid_check_master
// Directed bench for sysid_check_master. One instance uses the default
// parameters behind a sysid slave model with a programmable number of
// waitrequest cycles per read; a second instance with TIMEOUT_CYCLES=4 has a
// directly driven waitrequest for the stall-limit cases.
// -----------------------------------------------------------------------------
module tb_sysid_check_master;

   localparam logic [31:0] TS_EXP = 32'd1536932732;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        start_t = 1'b0;
   logic        wr_t = 1'b0;
   logic [31:0] id_word = 32'h0;
   logic [31:0] ts_word = TS_EXP;
   int          stall_n = 0;
   int          stall_cnt = 0;
   int          checks = 0;
   int          errors = 0;
   int          lat;
   int          dones;

   logic        avm_address, avm_read, avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        busy, done, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;

   logic        addr_t, read_t;
   logic [31:0] readdata_t;
   logic        busy_t, done_t, id_ok_t, ts_ok_t, timeout_t;
   logic [31:0] id_value_t, ts_value_t;

   always #5 clock = ~clock;

   // Slave model: register file indexed by address, stalling each read for
   // stall_n cycles before completing it.
   assign avm_readdata    = avm_address ? ts_word : id_word;
   assign avm_waitrequest = avm_read && (stall_cnt < stall_n);
   assign readdata_t      = addr_t ? ts_word : id_word;

   always @(posedge clock) begin
      if (avm_read && avm_waitrequest) stall_cnt <= stall_cnt + 1;
      else stall_cnt <= 0;
   end

   sysid_check_master dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .avm_address(avm_address), .avm_read(avm_read),
      .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
      .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok),
      .timeout(timeout), .id_value(id_value), .ts_value(ts_value)
   );

   sysid_check_master #(.TIMEOUT_CYCLES(4)) dut_to (
      .clock(clock), .reset_n(reset_n), .start(start_t),
      .avm_address(addr_t), .avm_read(read_t),
      .avm_readdata(readdata_t), .avm_waitrequest(wr_t),
      .busy(busy_t), .done(done_t), .id_ok(id_ok_t), .ts_ok(ts_ok_t),
      .timeout(timeout_t), .id_value(id_value_t), .ts_value(ts_value_t)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Pulses start on the selected instance and runs up to 'bound' edges.
   // lat is the edge count (start-sampling edge = 1) at which done is first
   // seen, 0 if never. With retrig set, start is re-pulsed mid-sequence and on
   // the done cycle, and the full window is run to count done pulses.
   task automatic applyStimulus(input logic sel, input logic retrig,
                                input int bound, output int lat_o,
                                output int dones_o);
      logic prev_wr, prev_rd, prev_addr, dn;
      lat_o = 0;
      dones_o = 0;
      if (sel) start_t = 1'b1; else start = 1'b1;
      for (int n = 1; n <= bound; n++) begin
         prev_wr   = sel ? wr_t : avm_waitrequest;
         prev_rd   = sel ? read_t : avm_read;
         prev_addr = sel ? addr_t : avm_address;
         tick();
         start   = 1'b0;
         start_t = 1'b0;
         dn = sel ? done_t : done;
         if (prev_wr && prev_rd && !dn) begin
            checkOutput("stall_read_held", {31'b0, sel ? read_t : avm_read}, 32'd1);
            checkOutput("stall_addr_held", {31'b0, sel ? addr_t : avm_address},
                        {31'b0, prev_addr});
         end
         if (dn) begin
            dones_o++;
            if (lat_o == 0) lat_o = n;
            if (!retrig) break;
         end
         if (retrig && !sel) start = (n == 3) || dn;
      end
      start = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_read", {31'b0, avm_read}, 32'd0);
      checkOutput("rst_done", {31'b0, done}, 32'd0);
      checkOutput("rst_id_value", id_value, 32'd0);
      checkOutput("rst_ts_value", ts_value, 32'd0);
      reset_n = 1'b1;
      tick();

      // Zero-wait pass
      applyStimulus(1'b0, 1'b0, 20, lat, dones);
      checkOutput("pass_latency", lat, 32'd3);
      checkOutput("pass_id_ok", {31'b0, id_ok}, 32'd1);
      checkOutput("pass_ts_ok", {31'b0, ts_ok}, 32'd1);
      checkOutput("pass_timeout", {31'b0, timeout}, 32'd0);
      checkOutput("pass_ts_value", ts_value, TS_EXP);
      checkOutput("pass_read_low", {31'b0, avm_read}, 32'd0);
      tick();
      checkOutput("pass_busy_off", {31'b0, busy}, 32'd0);
      checkOutput("pass_done_pulse", {31'b0, done}, 32'd0);

      // Wrong ID word
      id_word = 32'h0000_0001;
      tick();
      applyStimulus(1'b0, 1'b0, 20, lat, dones);
      checkOutput("badid_latency", lat, 32'd3);
      checkOutput("badid_id_ok", {31'b0, id_ok}, 32'd0);
      checkOutput("badid_ts_ok", {31'b0, ts_ok}, 32'd1);
      checkOutput("badid_id_value", id_value, 32'd1);

      // Wrong timestamp word
      id_word = 32'h0;
      ts_word = 32'h1234_5678;
      tick();
      applyStimulus(1'b0, 1'b0, 20, lat, dones);
      checkOutput("badts_id_ok", {31'b0, id_ok}, 32'd1);
      checkOutput("badts_ts_ok", {31'b0, ts_ok}, 32'd0);
      checkOutput("badts_ts_value", ts_value, 32'h1234_5678);
      tick();
      tick();
      checkOutput("badts_hold", {31'b0, ts_ok}, 32'd0);

      // Five stalled cycles on each read
      ts_word = TS_EXP;
      stall_n = 5;
      applyStimulus(1'b0, 1'b0, 40, lat, dones);
      checkOutput("stall_latency", lat, 32'd13);
      checkOutput("stall_id_ok", {31'b0, id_ok}, 32'd1);
      checkOutput("stall_ts_ok", {31'b0, ts_ok}, 32'd1);
      checkOutput("stall_timeout", {31'b0, timeout}, 32'd0);
      tick();

      // Stall limit: capture known values first, then hold waitrequest high
      id_word = 32'hA5A5_0001;
      wr_t = 1'b0;
      applyStimulus(1'b1, 1'b0, 20, lat, dones);
      checkOutput("to_pre_latency", lat, 32'd3);
      checkOutput("to_pre_id_value", id_value_t, 32'hA5A5_0001);
      tick();
      wr_t = 1'b1;
      applyStimulus(1'b1, 1'b0, 20, lat, dones);
      checkOutput("to_latency", lat, 32'd5);
      checkOutput("to_timeout", {31'b0, timeout_t}, 32'd1);
      checkOutput("to_id_ok", {31'b0, id_ok_t}, 32'd0);
      checkOutput("to_ts_ok", {31'b0, ts_ok_t}, 32'd0);
      checkOutput("to_read_low", {31'b0, read_t}, 32'd0);
      checkOutput("to_id_value_held", id_value_t, 32'hA5A5_0001);
      checkOutput("to_ts_value_held", ts_value_t, TS_EXP);
      for (int i = 0; i < 3; i++) tick();
      checkOutput("to_timeout_hold", {31'b0, timeout_t}, 32'd1);
      wr_t = 1'b0;
      id_word = 32'h0;
      applyStimulus(1'b1, 1'b0, 20, lat, dones);
      checkOutput("to_recover_timeout", {31'b0, timeout_t}, 32'd0);
      checkOutput("to_recover_ts_ok", {31'b0, ts_ok_t}, 32'd1);
      tick();

      // Start re-pulsed while busy and on the done cycle
      stall_n = 2;
      applyStimulus(1'b0, 1'b1, 30, lat, dones);
      checkOutput("retrig_latency", lat, 32'd7);
      checkOutput("retrig_done_count", dones, 32'd1);
      checkOutput("retrig_busy_end", {31'b0, busy}, 32'd0);

      // Reset during RD_TS
      stall_n = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checkOutput("mid_busy", {31'b0, busy}, 32'd1);
      checkOutput("mid_address", {31'b0, avm_address}, 32'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("arst_busy", {31'b0, busy}, 32'd0);
      checkOutput("arst_read", {31'b0, avm_read}, 32'd0);
      checkOutput("arst_address", {31'b0, avm_address}, 32'd0);
      checkOutput("arst_ts_value", ts_value, 32'd0);
      checkOutput("arst_ts_value_t", ts_value_t, 32'd0);
      checkOutput("arst_ok", {30'b0, id_ok, ts_ok}, 32'd0);
      tick();
      reset_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done) dones++;
      end
      checkOutput("arst_no_done", dones, 32'd0);
      applyStimulus(1'b0, 1'b0, 20, lat, dones);
      checkOutput("after_rst_latency", lat, 32'd3);
      checkOutput("after_rst_id_ok", {31'b0, id_ok}, 32'd1);
      checkOutput("after_rst_ts_ok", {31'b0, ts_ok}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard stop in case a wait above never resolves.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/sysid_check_master.md
SYSID_CHECK_MASTER -- requirements
Module: sysid_check_master

Interface
REQ-001 SHALL have parameter EXP_ID, default 32'h0000_0000, expected system ID word (address 0).
REQ-002 SHALL have parameter EXP_TIMESTAMP, default 32'd1536932732, expected build timestamp word (address 1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum waitrequest-stalled cycles per read; legal range 1..65535.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports named clock and reset_n.
REQ-005 clock  input  1  sole clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  single-cycle check request.
REQ-008 avm_address  output  1  Avalon-MM word address to sysid slave (0 = ID, 1 = timestamp).
REQ-009 avm_read  output  1  Avalon-MM read strobe.
REQ-010 avm_readdata  input  32  read data from slave.
REQ-011 avm_waitrequest  input  1  slave stall; tie 0 for zero-wait sysid slave.
REQ-012 busy  output  1  check sequence in progress.
REQ-013 done  output  1  one-cycle pulse when sequence ends (pass, fail or timeout).
REQ-014 id_ok  output  1  captured ID equals EXP_ID.
REQ-015 ts_ok  output  1  captured timestamp equals EXP_TIMESTAMP.
REQ-016 timeout  output  1  last sequence aborted on stall limit.
REQ-017 id_value  output  32  last captured ID word.
REQ-018 ts_value  output  32  last captured timestamp word.

Function
REQ-019 SHALL implement states IDLE, RD_ID, RD_TS, FINISH.
REQ-020 IDLE: start=1 -> RD_ID next cycle; busy asserts same edge; id_ok, ts_ok, timeout cleared same edge.
REQ-021 RD_ID: avm_read=1, avm_address=0; transfer completes on a cycle with avm_read=1 and avm_waitrequest=0; avm_readdata captured into id_value that edge; -> RD_TS.
REQ-022 RD_TS: avm_read=1, avm_address=1; on completion capture into ts_value; -> FINISH.
REQ-023 avm_address and avm_read SHALL be registered and held stable while avm_waitrequest=1.
REQ-024 With avm_waitrequest tied 0, start to done pulse latency SHALL be exactly 3 cycles (RD_ID, RD_TS, FINISH each one cycle).
REQ-025 FINISH: done=1 for one cycle, busy=0 on exit, id_ok/ts_ok registered from comparisons of captured words; -> IDLE.
REQ-026 Stall counter (16 bit) SHALL reset to 0 on entry to each read state and increment per cycle with avm_waitrequest=1.
REQ-027 Counter reaching TIMEOUT_CYCLES with waitrequest still 1 -> FINISH with timeout=1, id_ok=0, ts_ok=0; avm_read deasserted next cycle; uncaptured value registers keep prior contents.
REQ-028 start while busy SHALL be ignored (no queueing, no restart).
REQ-029 start in the same cycle as the FINISH done pulse SHALL be ignored; new start accepted from IDLE only.
REQ-030 id_ok, ts_ok, timeout, id_value, ts_value SHALL hold until the next accepted start.
REQ-031 avm_read SHALL be 0 in IDLE and FINISH.

Reset
REQ-032 reset_n=0 SHALL immediately force state IDLE, avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0, stall counter=0.
REQ-033 Reset mid-sequence SHALL abort without a done pulse; first accepted start after reset release begins a fresh sequence.

Structure
REQ-034 State enumeration and address constants (ADDR_ID=0, ADDR_TS=1) SHALL live in shared package sysid_pkg.
REQ-035 Stall counter SHALL be a sub-module sysid_stall_timer (clear, enable, limit, expired).
REQ-036 Single always_ff state machine; no latches; outputs all registered except done-derived pulse.

Verification
REQ-037 Zero-wait slave returning 0 / 1536932732, start pulse -> done at cycle 3, id_ok=1, ts_ok=1, timeout=0.
REQ-038 Slave returns 32'h0000_0001 at address 0 -> id_ok=0, ts_ok=1, id_value=1.
REQ-039 waitrequest held 5 cycles on each read -> done at cycle 13, both ok=1, avm_address/avm_read stable during stalls.
REQ-040 TIMEOUT_CYCLES=4, waitrequest stuck 1 -> done after 4 stalled cycles in RD_ID, timeout=1, id_ok=ts_ok=0.
REQ-041 start re-pulsed while busy and on done cycle -> exactly one done pulse, no second sequence.
REQ-042 reset_n asserted during RD_TS -> all outputs zero immediately, no done pulse; subsequent start passes normally.
